// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter
//   Two-master pipelined arbiter in front of the combinational instruction
//   ROM read port. Master 0 is the IF-stage fetch port. Master 1 is the
//   secondary reader (debug/loader or constant-pool reads).
//   Each accepted request passes through two register stages:
//     S1: owner, address and misalignment flag; drives the ROM.
//     S2: the returned word, tagged with its owner.
//   A request accepted in cycle N is answered in cycle N+2. The arbiter
//   accepts one request per cycle.
//
// Configuration macro:
//   INST_ROM_ARB_RR_EN  defined   -> round-robin on contention (1-bit pointer)
//                       undefined -> fixed priority, master 0 wins
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   m0_req_i / m0_addr_i     fetch request and byte address
//   m0_gnt_o                 fetch accepted this cycle (combinational)
//   m0_rvalid_o/_rdata_o/_rerr_o  fetch response (err = misaligned)
//   m1_*                     same set of ports for master 1
//   flush_i                  kill in-flight and same-cycle master-0 accesses
//   stallreq_o               master 0 requesting but not granted
//   rom_ce_o / rom_addr_o    ROM chip enable and byte address
//   rom_inst_i               ROM combinational read data
module inst_rom_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_rerr_o,
  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_rerr_o,
  input  logic              flush_i,
  output logic              stallreq_o,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_inst_i
);

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  logic              m0_elig;
  logic              m1_elig;
  logic              m1_wins;
  logic [ADDR_W-1:0] sel_addr;

  logic              s1_valid_d, s1_valid_q;
  logic              s1_owner_d, s1_owner_q;
  logic              s1_err_d,   s1_err_q;
  logic [ADDR_W-1:0] s1_addr_d,  s1_addr_q;

  logic              s2_valid_d, s2_valid_q;
  logic              s2_owner_d, s2_owner_q;
  logic              s2_err_d,   s2_err_q;
  logic [DATA_W-1:0] s2_data_d,  s2_data_q;

`ifdef INST_ROM_ARB_RR_EN
  // ptr_q names the master preferred on the next contended cycle.
  logic ptr_d, ptr_q;
  logic contended;
`endif

  // Arbitration. Master 0 is ineligible during a flush, so master 1 can win
  // that cycle. Nothing is granted while reset is held.
  always_comb begin
    m0_elig = m0_req_i & ~flush_i & ~rst;
    m1_elig = m1_req_i & ~rst;
`ifdef INST_ROM_ARB_RR_EN
    contended = m0_elig & m1_elig;
    m1_wins   = m1_elig & (~m0_elig | ptr_q);
    ptr_d     = ptr_q;
    // The loser becomes the preferred master.
    if (contended) ptr_d = ~m1_wins;
`else
    m1_wins   = m1_elig & ~m0_elig;
`endif
    sel_addr  = m1_wins ? m1_addr_i : m0_addr_i;
  end

  assign m0_gnt_o   = m0_elig & ~m1_wins;
  assign m1_gnt_o   = m1_wins;
  assign stallreq_o = m0_req_i & ~m0_gnt_o & ~flush_i & ~rst;

  // Pipeline next-state. A flush drops a master-0 entry as it moves from S1
  // to S2. The S2 entry being presented during the flush cycle is masked at
  // the output instead.
  always_comb begin
    s1_valid_d = m0_elig | m1_elig;
    s1_owner_d = m1_wins;
    s1_addr_d  = sel_addr;
    s1_err_d   = s1_valid_d & (sel_addr[1:0] != 2'b00);

    s2_valid_d = s1_valid_q & ~(flush_i & ~s1_owner_q);
    s2_owner_d = s1_owner_q;
    s2_err_d   = s1_err_q;
    s2_data_d  = s1_err_q ? ZERO_WORD : rom_inst_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_owner_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_owner_q <= 1'b0;
      s2_err_q   <= 1'b0;
      s2_data_q  <= '0;
`ifdef INST_ROM_ARB_RR_EN
      ptr_q      <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_owner_q <= s1_owner_d;
      s1_err_q   <= s1_err_d;
      s1_addr_q  <= s1_addr_d;
      s2_valid_q <= s2_valid_d;
      s2_owner_q <= s2_owner_d;
      s2_err_q   <= s2_err_d;
      s2_data_q  <= s2_data_d;
`ifdef INST_ROM_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  // The outputs are gated by rst as well. The registers clear only at the
  // reset edge, so without this gating the first reset cycle would show
  // stale state.
  assign rom_ce_o    = s1_valid_q & ~s1_err_q & ~rst;
  assign rom_addr_o  = rom_ce_o ? s1_addr_q : '0;

  assign m0_rvalid_o = s2_valid_q & ~s2_owner_q & ~flush_i & ~rst;
  assign m1_rvalid_o = s2_valid_q &  s2_owner_q & ~rst;
  assign m0_rdata_o  = m0_rvalid_o ? s2_data_q : ZERO_WORD;
  assign m1_rdata_o  = m1_rvalid_o ? s2_data_q : ZERO_WORD;
  assign m0_rerr_o   = m0_rvalid_o & s2_err_q;
  assign m1_rerr_o   = m1_rvalid_o & s2_err_q;

endmodule
